// File: rtl/lab1_seq_evaluator.sv
// lab1_seq_evaluator: serial six-operand insertion sort followed by a three-cycle shared-multiplier rule evaluator
module lab1_seq_evaluator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic [2:0] in_rule,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out
);
    typedef enum logic [2:0] {LOAD, MUL0, MUL1, SUM, OUT} state_t;
    state_t     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic [2:0] rule_q, rule_d;
    logic [3:0] s_q [6];
    logic [3:0] s_d [6];
    logic [3:0] ins [6];
    logic [5:0] le;
    logic [7:0] p0_q, p0_d, p1_q, p1_d, prod;
    logic [9:0] out_q, out_d;
    logic [3:0] a, b, c, d, e, f, ma, mb;
    logic       accept;

    assign in_ready  = rst_n && state_q == LOAD;
    assign out_valid = state_q == OUT;
    assign out       = out_q;
    assign accept    = in_valid && in_ready;

    for (genvar g = 0; g < 6; g++) begin : g_ins
        assign le[g] = 3'(g) < count_q && s_q[g] <= in_data;
        if (g == 0) begin : g_first
            assign ins[g] = le[g] ? s_q[g] : in_data;
        end else begin : g_rest
            assign ins[g] = le[g] ? s_q[g] : le[g-1] ? in_data : s_q[g-1];
        end
    end

    // route the sorted operands to a..f according to the latched permutation select
    always_comb begin
        {a, b, c, d, e, f} = {s_q[0], s_q[1], s_q[2], s_q[3], s_q[4], s_q[5]};
        case (rule_q[2:1])
            2'b01:   {a, b, c, d, e, f} = {s_q[1], s_q[3], s_q[5], s_q[0], s_q[2], s_q[4]};
            2'b10:   {a, b, c, d, e, f} = {s_q[0], s_q[2], s_q[4], s_q[5], s_q[3], s_q[1]};
            2'b11:   {a, b, c, d, e, f} = {s_q[5], s_q[3], s_q[1], s_q[0], s_q[2], s_q[4]};
            default: ;
        endcase
    end

    assign ma   = state_q == MUL0 ? (rule_q[0] ? b : a) : (rule_q[0] ? c : b);
    assign mb   = state_q == MUL0 ? (rule_q[0] ? c : b) : (rule_q[0] ? d : c);
    assign prod = {4'b0, ma} * {4'b0, mb};

    // next-state: insert in LOAD, two multiply steps, combine in SUM, hold in OUT until accepted
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rule_d  = rule_q;
        s_d     = s_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        out_d   = out_q;
        case (state_q)
            LOAD: if (accept) begin
                s_d     = ins;
                count_d = count_q + 3'd1;
                rule_d  = count_q == 3'd0 ? in_rule : rule_q;
                state_d = count_q == 3'd5 ? MUL0 : LOAD;
            end
            MUL0: begin
                p0_d    = prod;
                state_d = MUL1;
            end
            MUL1: begin
                p1_d    = prod;
                state_d = SUM;
            end
            SUM: begin
                out_d   = rule_q[0] ? {2'b0, p0_q} - {2'b0, p1_q} + ({6'b0, f} >> 1)
                                    : {2'b0, p0_q} + {2'b0, p1_q} - {4'b0, e, 2'b0};
                state_d = OUT;
            end
            OUT: if (out_ready) begin
                state_d = LOAD;
                count_d = '0;
                s_d     = '{default: '0};
            end
            default: state_d = LOAD;
        endcase
    end

    // state register; reset aborts any partial set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            count_q <= '0;
            rule_q  <= '0;
            s_q     <= '{default: '0};
            p0_q    <= '0;
            p1_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rule_q  <= rule_d;
            s_q     <= s_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_lab1_seq_evaluator.sv
// tb_lab1_seq_evaluator: directed and randomized checks of the serial sort-and-evaluate block
module tb_lab1_seq_evaluator;
    logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [3:0] in_data = 0;
    logic [2:0] in_rule = 0;
    logic       in_ready, out_valid;
    logic [9:0] out;
    int         tests = 0, fails = 0, cyc = 0;

    logic [23:0] t_ops [13] = '{24'h951413, 24'h951413, 24'h951413, 24'h951413, 24'h951413,
                                24'h951413, 24'h951413, 24'h951413, 24'hFF0000, 24'hFFFFFF,
                                24'hFFFFFF, 24'h456789, 24'h177222};
    logic [2:0]  t_rule [13] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b101, 3'b110,
                                 3'b111, 3'b000, 3'b000, 3'b101, 3'b000, 3'b001};
    logic [9:0]  t_exp [13] = '{-10'sd16, -10'sd5, 10'sd29, 10'sd28, 10'sd2, -10'sd30, 10'sd28,
                                10'sd5, -10'sd60, 10'sd390, 10'sd7, 10'sd18, 10'sd3};

    lab1_seq_evaluator dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_rule(in_rule), .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] ref_eval(input logic [23:0] ops, input logic [2:0] rule);
        int o [6];
        int v [6];
        int t;
        int perm [4][6] = '{'{0, 1, 2, 3, 4, 5}, '{1, 3, 5, 0, 2, 4}, '{0, 2, 4, 5, 3, 1}, '{5, 3, 1, 0, 2, 4}};
        for (int i = 0; i < 6; i++) o[i] = int'(ops[4*i +: 4]);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5 - i; j++)
                if (o[j] > o[j+1]) begin t = o[j]; o[j] = o[j+1]; o[j+1] = t; end
        for (int i = 0; i < 6; i++) v[i] = o[perm[rule[2:1]][i]];
        t = rule[0] ? v[1]*v[2] - v[2]*v[3] + v[5]/2 : v[0]*v[1] + v[1]*v[2] - 4*v[4];
        return 10'(t);
    endfunction

    task automatic load_set(input logic [23:0] ops, input logic [2:0] rule, input int max_gap, output bit to);
        to = 0;
        for (int i = 0; i < 6; i++) begin
            int g = max_gap > 0 ? int'($urandom_range(max_gap, 0)) : 0;
            int w = 0;
            repeat (g) begin @(posedge clk); #1; end
            in_valid = 1;
            in_data  = ops[4*i +: 4];
            in_rule  = i == 0 ? rule : 3'($urandom);
            @(negedge clk);
            while (!in_ready && w < 50) begin @(negedge clk); w++; end
            if (!in_ready) to = 1;
            @(posedge clk); #1;
            in_valid = 0;
            in_data  = 4'($urandom);
        end
    endtask

    task automatic wait_out(output bit to);
        int w = 0;
        @(negedge clk);
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        to = !out_valid;
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if (out !== 10'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: out=%0d out_valid=%b in_ready=%b expected 0/0/0", out, out_valid, in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_held: in_ready=%b out_valid=%b expected 0/0", in_ready, out_valid);
        end
        rst_n = 1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 10'd0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b out=%0d expected 1/0/0", in_ready, out_valid, out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_eval;
        bit to;
        for (int i = 0; i < 13; i++) begin
            load_set(t_ops[i], t_rule[i], i % 2, to);
            tests++;
            if (to) begin fails++; $display("FAIL eval_load[%0d]: in_ready never high", i); end
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                tests++;
                if (out_valid !== (k == 3)) begin
                    fails++;
                    $display("FAIL eval_latency[%0d]: edge %0d out_valid=%b expected %b", i, k + 1, out_valid, k == 3);
                end
            end
            tests++;
            if (out !== t_exp[i]) begin
                fails++;
                $display("FAIL eval_value[%0d]: out=%0d expected %0d", i, $signed(out), $signed(t_exp[i]));
            end
            out_ready = 1;
            @(posedge clk); #1;
            out_ready = 0;
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== t_exp[i]) begin
                fails++;
                $display("FAIL eval_handshake[%0d]: out_valid=%b in_ready=%b out=%0d expected 0/1/%0d",
                         i, out_valid, in_ready, $signed(out), $signed(t_exp[i]));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        bit to, to2;
        int c0;
        logic [23:0] ops [3] = '{24'h951413, 24'h951413, 24'hFFFFFF};
        logic [2:0]  rl [3]  = '{3'b000, 3'b001, 3'b000};
        logic [9:0]  ex [3]  = '{-10'sd16, -10'sd5, 10'sd390};
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            c0 = cyc;
            load_set(ops[i], rl[i], 0, to);
            wait_out(to2);
            tests++;
            if (to || to2 || out !== ex[i]) begin
                fails++;
                $display("FAIL b2b_value[%0d]: out=%0d timeout=%b expected %0d", i, $signed(out), to | to2, $signed(ex[i]));
            end
            @(posedge clk); #1;
            tests++;
            if (cyc - c0 != 10 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_period[%0d]: cycles=%0d out_valid=%b in_ready=%b expected 10/0/1",
                         i, cyc - c0, out_valid, in_ready);
            end
        end
        out_ready = 0;
    endtask

    task automatic test_backpressure;
        bit to, to2;
        load_set(24'h951413, 3'b000, 0, to);
        wait_out(to2);
        tests++;
        if (to || to2 || out !== 10'h3F0) begin
            fails++;
            $display("FAIL bp_value: out=%0d timeout=%b expected -16", $signed(out), to | to2);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid = k % 2 == 0;
            in_data  = 4'd15;
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out !== 10'h3F0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: out_valid=%b out=%0d in_ready=%b expected 1/-16/0",
                         k, out_valid, $signed(out), in_ready);
            end
        end
        @(posedge clk); #1;
        in_valid  = 0;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        load_set(24'hFF0000, 3'b000, 0, to);
        wait_out(to2);
        tests++;
        if (to || to2 || out !== -10'sd60) begin
            fails++;
            $display("FAIL bp_next_set: out=%0d timeout=%b expected -60", $signed(out), to | to2);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_mid_reset;
        bit to, to2;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1;
            in_data  = 4'd15;
            in_rule  = 3'b000;
            @(posedge clk); #1;
        end
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        tests++;
        if (out !== 10'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL midload_reset: out=%0d out_valid=%b in_ready=%b expected 0/0/0", $signed(out), out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        load_set(24'h951413, 3'b001, 1, to);
        wait_out(to2);
        tests++;
        if (to || to2 || out !== -10'sd5) begin
            fails++;
            $display("FAIL midload_fresh: out=%0d timeout=%b expected -5", $signed(out), to | to2);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        load_set(24'hFFFFFF, 3'b000, 0, to);
        #2 rst_n = 0;
        #1;
        tests++;
        if (out !== 10'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midcompute_reset: out=%0d out_valid=%b expected 0/0", $signed(out), out_valid);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        load_set(24'hFF0000, 3'b000, 0, to);
        wait_out(to2);
        tests++;
        if (to || to2 || out !== -10'sd60) begin
            fails++;
            $display("FAIL midcompute_fresh: out=%0d timeout=%b expected -60", $signed(out), to | to2);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_random;
        bit to;
        for (int n = 0; n < 1000; n++) begin
            logic [23:0] ops = 24'($urandom);
            logic [2:0]  rule = 3'($urandom);
            logic [9:0]  exp = ref_eval(ops, rule);
            bit seen = 0, done = 0;
            int w = 0;
            load_set(ops, rule, 3, to);
            if (to) begin
                tests++;
                fails++;
                $display("FAIL rand_load[%0d]: in_ready never high", n);
            end
            while (!done && w < 200) begin
                @(negedge clk);
                if (out_valid) begin
                    tests++;
                    if (out !== exp) begin
                        fails++;
                        $display("FAIL rand_value[%0d]: out=%0d expected %0d (ops=%h rule=%b seen=%b)",
                                 n, $signed(out), $signed(exp), ops, rule, seen);
                    end
                    seen = 1;
                    done = out_ready;
                end
                @(posedge clk); #1;
                out_ready = 1'($urandom);
                w++;
            end
            tests++;
            if (!done || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL rand_handshake[%0d]: done=%b out_valid=%b expected 1/0", n, done, out_valid);
            end
        end
        out_ready = 0;
    endtask

    initial begin
        test_reset;
        test_eval;
        test_back_to_back;
        test_backpressure;
        test_mid_reset;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule
